// File: rtl/stream_min2_finder.sv
// stream_min2_finder: scans a DEPTH-element frame arriving on a valid/ready
// stream and reports the two smallest (mode 0) or two largest (mode 1)
// unsigned values together with their frame indices.
module stream_min2_finder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ext1,
  output logic [WIDTH-1:0] ext2,
  output logic [IDX_W-1:0] idx1,
  output logic [IDX_W-1:0] idx2
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic             mode_q;   // mode latched on accepted start
  logic [IDX_W-1:0] cnt;      // index of the next beat in the frame
  logic             e2v;      // ext2 holds a real element
  logic             accept;
  logic             last;

  // Strict "better" compare: ties never win, so earlier occurrences stick.
  function automatic logic better(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic             m);
    return m ? (a > b) : (a < b);
  endfunction

  assign in_ready = (state == SCAN);
  assign busy     = (state == SCAN);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == IDX_W'(DEPTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: frame runs for exactly DEPTH accepted beats, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (accept && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: frame setup on start, running top-2 update per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      cnt    <= '0;
      e2v    <= 1'b0;
      ext1   <= '0;
      ext2   <= '0;
      idx1   <= '0;
      idx2   <= '0;
    end else if (state == IDLE && start) begin
      mode_q <= mode;
      cnt    <= '0;
      e2v    <= 1'b0;
    end else if (accept) begin
      // Hold at DEPTH-1 on the last beat so the counter never wraps.
      if (!last) cnt <= cnt + IDX_W'(1);
      if (cnt == '0) begin
        ext1 <= in_data;
        idx1 <= '0;
        e2v  <= 1'b0;
      end else if (better(in_data, ext1, mode_q)) begin
        ext2 <= ext1;
        idx2 <= idx1;
        ext1 <= in_data;
        idx1 <= cnt;
        e2v  <= 1'b1;
      end else if (!e2v || better(in_data, ext2, mode_q)) begin
        // Duplicates of ext1 land here, so ext2 == ext1 is possible.
        ext2 <= in_data;
        idx2 <= cnt;
        e2v  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/stream_min2_finder.md
Name: stream_min2_finder

Overview:
- Sequential, parametrised successor to the combinational 16-input min finder.
- Accepts a frame of DEPTH unsigned WIDTH-bit elements, one per beat over a valid/ready stream.
- Reports the two extreme values and the index of each: the two smallest, or the two largest in max mode.
- Sits between a sample source (FIFO or register bank) and the selection logic that consumes min1/min2.

Parameters:
WIDTH, 4, element width in bits (>=1)
DEPTH, 16, elements per frame (>=2; DEPTH<2 is illegal)
IDX_W, $clog2(DEPTH), index width (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a frame; ignored unless the block is IDLE
mode  input  1  0 = find two smallest, 1 = find two largest; sampled on accepted start
in_valid  input  1  element present on in_data
in_data  input  WIDTH  element value, unsigned
in_ready  output  1  block accepts an element this cycle
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse; results valid
ext1  output  WIDTH  best value (min1, or max1 in max mode)
ext2  output  WIDTH  second-best value
idx1  output  IDX_W  frame index of ext1
idx2  output  IDX_W  frame index of ext2

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=0, busy=0, done=0; ext1, ext2, idx1, idx2 = 0; beat counter=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on start=1. Latch mode, clear counter and the ext2-valid flag, set busy=1 next cycle. Results from the previous frame hold until this point.
- SCAN:
  - in_ready=1; a beat is accepted when in_valid && in_ready.
  - in_valid=0 stalls with no state change.
  - Counter k increments per accepted beat.
- Update rule for each accepted beat x at index k. "better" means < (mode 0) or > (mode 1), strict:
  - k==0: ext1<=x, idx1<=0; ext2 is marked invalid.
  - else if x better than ext1: ext2<=ext1, idx2<=idx1, ext1<=x, idx1<=k, mark ext2 valid.
  - else if ext2 invalid or x better than ext2: ext2<=x, idx2<=k, mark ext2 valid.
  - else: no change.
- Tie rules:
  - Equal values never displace ext1, so idx1 is the earliest occurrence.
  - A duplicate of ext1 may become ext2, so ext2==ext1 is legal.
- When the beat at k==DEPTH-1 is accepted, move to DONE. in_ready drops in the following cycle, so exactly DEPTH beats are accepted.
- DONE (one cycle): done=1, busy=0 (falls coincident with done), in_ready=0, then go to IDLE. Latency is one cycle from the last accepted beat to done.
- Outputs ext1/ext2/idx1/idx2 update during SCAN. They are only guaranteed meaningful when done=1, and are held stable from done until the next accepted start.
- start asserted during SCAN or DONE is ignored, with no effect on the frame.
- mode changes during a frame have no effect.
- rst_n low mid-frame aborts immediately to reset values; a new start is required.
- Width: all comparisons unsigned, full WIDTH. The counter is IDX_W bits and never wraps within a frame.

Test Plan:
- Mode 0, frame 2,3,1,2,5,6,9,9,9,9,9,9,9,9,9,9 -> done with ext1=1 idx1=2, ext2=2 idx2=0.
- Mode 0, frame 1,4,2,1,2,12,9x10 -> ext1=1 idx1=0, ext2=1 idx2=3 (duplicate minimum).
- Mode 0, frame 5,2,10,0,4,1,9x10, with in_valid dropped for 3 cycles after beats 2 and 7 -> ext1=0 idx1=3, ext2=1 idx2=5. done comes exactly 1 cycle after the 16th accepted beat, and in_ready is never high after it.
- Mode 1, frame 0..15 ascending, then a second frame of all 15 -> first: ext1=15 idx1=15, ext2=14 idx2=14; second: ext1=15 idx1=0, ext2=15 idx2=1.
- start re-pulsed at beat 5 of a frame, mode toggled mid-frame -> frame completes after 16 beats with the original mode and correct results.
- rst_n pulsed low at beat 8 -> all outputs 0 and state IDLE asynchronously; a subsequent full frame gives correct results.
